module_mux_n1_reg: RTL and testbench
====================================

MODULE_MUX_N1_REG -- requirements
Module: module_mux_n1_reg

Interface
REQ-001 Parameter WIDTH SHALL be: default 4, bits per data channel, legal range 1..32.
REQ-002 Parameter N_IN SHALL be: default 4, number of input channels, legal range 2..16, not necessarily a power of two.
REQ-003 Parameter SEL_W SHALL be: default $clog2(N_IN), width of the select and grant fields.
REQ-004 Port clk SHALL be: input, 1 bit, single clock, rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, reset that is synchronous and active-high.
REQ-006 Port mode SHALL be: input, 1 bit; 0 = manual select, 1 = round-robin.
REQ-007 Port sel SHALL be: input, SEL_W bits, channel index used in manual mode.
REQ-008 Port in_data SHALL be: input, N_IN*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 Port in_valid SHALL be: input, N_IN bits, per-channel valid.
REQ-010 Port in_ready SHALL be: output, N_IN bits, per-channel accept (one-hot or zero).
REQ-011 Port out_data SHALL be: output, WIDTH bits, registered selected data.
REQ-012 Port out_valid SHALL be: output, 1 bit, out_data holds an untransferred word.
REQ-013 Port out_ready SHALL be: input, 1 bit, downstream accept.
REQ-014 Port out_sel SHALL be: output, SEL_W bits, channel index of the word in out_data.

Function
REQ-015 Transfer rules SHALL be: an input transfer occurs on channel k when in_valid[k] and in_ready[k] are both 1 at a clk edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-016 Load condition SHALL be: load_en = !out_valid || out_ready; when load_en = 0, all in_ready bits SHALL be 0.
REQ-017 Manual-mode grant SHALL be: when mode = 0, the grant is channel sel only if sel < N_IN and in_valid[sel] = 1; otherwise there is no grant.
REQ-018 Round-robin grant SHALL be: when mode = 1, the grant is the first k with in_valid[k] = 1, searching from index ptr upward with wrap from N_IN-1 to 0.
REQ-019 Grant output SHALL be: in_ready[k] = load_en && (grant == k); in_ready is combinational from in_valid, sel, mode, ptr, out_valid and out_ready.
REQ-020 Output register SHALL be: on an input transfer, at the next edge out_data <= the channel's data, out_sel <= k, out_valid <= 1; latency is 1 cycle.
REQ-021 Output without a new load SHALL be: on an output transfer with no simultaneous input transfer, out_valid <= 0, and out_data and out_sel hold their values.
REQ-022 Simultaneous transfers SHALL be: when an input and an output transfer occur in the same cycle, the register reloads with the new word and out_valid stays 1, giving full throughput of 1 word/cycle.
REQ-023 Backpressure SHALL be: while out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL remain stable.
REQ-024 Pointer update SHALL be: ptr <= (k+1) mod N_IN after each round-robin input transfer on channel k; ptr is unchanged in manual mode and on idle cycles.
REQ-025 Mode change SHALL be: changing mode takes effect in the same cycle's grant; ptr is preserved across mode changes.

Reset
REQ-026 Reset values SHALL be: on rst = 1 at a clk edge, out_valid <= 0, out_data <= 0, out_sel <= 0 and ptr <= 0.
REQ-027 Reset outputs SHALL be: while rst = 1, in_ready SHALL be all 0.
REQ-028 Reset mid-operation SHALL be: reset during backpressure discards the held word with no transfer reported.

Configuration
REQ-029 Macro MUX_RR_EN SHALL control round-robin: when defined, round-robin mode and ptr exist as in REQ-018/024.
REQ-030 Without MUX_RR_EN, the block SHALL behave as follows: mode is ignored (treated as 0), no ptr register exists, and manual behaviour is unchanged.

Verification
REQ-031 Scenario manual select SHALL be: mode=0, sel=2, in_valid=4'b0100, ch2=4'hE, out_ready=1 -> next cycle out_data=4'hE, out_sel=2, out_valid=1.
REQ-032 Scenario backpressure SHALL be: out_valid=1, out_ready=0 for 3 cycles with new valid inputs -> in_ready=0, and out_data is unchanged for 3 cycles.
REQ-033 Scenario round-robin fairness SHALL be: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
REQ-034 Scenario sparse wrap SHALL be: mode=1, ptr=3, in_valid=4'b0011 -> grant 0 then 1, and ptr=2 after.
REQ-035 Scenario out-of-range select SHALL be: N_IN=3, mode=0, sel=3 -> in_ready=0 and out_valid stays 0.
REQ-036 Scenario reset under load SHALL be: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0 and ptr=0.

Source files
------------

// File: rtl/module_mux_n1_reg.sv
// Registered N:1 multiplexer with valid/ready handshakes and manual or round-robin channel grant.
// Define MUX_RR_EN to build round-robin mode and its rotating priority pointer; otherwise mode is ignored.
module module_mux_n1_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);

  localparam int unsigned LAST = N_IN - 1;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_mode;
  logic             w_load_en;
  logic             w_man_vld;
  logic [SEL_W-1:0] w_man_idx;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_xfer_in;
  logic [WIDTH-1:0] w_grant_data;

  // Manual grant: sel must name an existing channel that is currently valid.
  always_comb begin
    w_man_vld = 1'b0;
    w_man_idx = sel;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if ((sel == SEL_W'(k)) && in_valid[k]) begin
        w_man_vld = 1'b1;
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] r_ptr;
  logic             w_hi_vld;
  logic [SEL_W-1:0] w_hi_idx;
  logic             w_lo_vld;
  logic [SEL_W-1:0] w_lo_idx;

  assign w_mode = mode;

  // Round-robin: lowest valid index at or above ptr, else lowest valid index overall (wrap).
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int unsigned k = LAST + 1; k > 0; k--) begin
      if (in_valid[k-1]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = SEL_W'(k-1);
        if (SEL_W'(k-1) >= r_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = SEL_W'(k-1);
        end
      end
    end
    w_rr_vld = w_lo_vld;
    w_rr_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
  end

  // Pointer advances past the granted channel only on round-robin transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer_in && w_mode) begin
      if (w_grant_idx == SEL_W'(LAST)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grant_idx + SEL_W'(1);
      end
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_mode        = 1'b0;
  assign w_rr_vld      = 1'b0;
  assign w_rr_idx      = '0;
`endif

  assign w_grant_vld = w_mode ? w_rr_vld : w_man_vld;
  assign w_grant_idx = w_mode ? w_rr_idx : w_man_idx;
  assign w_load_en   = !r_out_valid || out_ready;
  assign w_xfer_in   = w_load_en && w_grant_vld && !rst;

  // One-hot accept towards the granted channel; all zero when no load can happen.
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (w_xfer_in && (w_grant_idx == SEL_W'(k))) begin
        in_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (w_grant_idx == SEL_W'(k)) begin
        w_grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: reload on accept (also while draining), clear valid on a bare drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer_in) begin
      r_out_data  <= w_grant_data;
      r_out_sel   <= w_grant_idx;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_module_mux_n1_reg.sv
// Directed bench for module_mux_n1_reg: a 4-channel instance for the main flow and a
// 3-channel instance for the out-of-range select case.
module tb_module_mux_n1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  logic        mode3;
  logic [1:0]  sel3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_sel3;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] ch [4];

  always #5 clk = ~clk;

  module_mux_n1_reg #(.WIDTH(4), .N_IN(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  module_mux_n1_reg #(.WIDTH(4), .N_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ch[0] = 4'hA; ch[1] = 4'hB; ch[2] = 4'hE; ch[3] = 4'hD;
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = 16'hDEBA;
    in_valid = 4'hF; out_ready = 1'b0;
    mode3 = 1'b0; sel3 = 2'd3; in_data3 = 12'h975; in_valid3 = 3'b111; out_ready3 = 1'b1;

    // reset
    #1;
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_in_ready3", in_ready3, 3'b000);
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_sel", out_sel, 2'd0);
    chk("rst_out_valid3", out_valid3, 1'b0);
    tick();

    // manual select of channel 2
    rst = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("man_in_ready", in_ready, 4'b0100);
    chk("oor_in_ready3", in_ready3, 3'b000);
    tick();
    chk("man_out_data", out_data, 4'hE);
    chk("man_out_sel", out_sel, 2'd2);
    chk("man_out_valid", out_valid, 1'b1);
    chk("oor_out_valid3", out_valid3, 1'b0);

    // backpressure for three cycles with new valid inputs
    out_ready = 1'b0; in_valid = 4'hF; sel = 2'd1; sel3 = 2'd2;
    #1;
    chk("bp_in_ready", in_ready, 4'b0000);
    chk("n3_in_ready3", in_ready3, 3'b100);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_out_data", out_data, 4'hE);
      chk("bp_out_sel", out_sel, 2'd2);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready_hold", in_ready, 4'b0000);
    end
    chk("n3_out_data3", out_data3, 4'h9);
    chk("n3_out_sel3", out_sel3, 2'd2);

    // release: drain and reload in the same cycle
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 4'b0010);
    tick();
    chk("rel_out_data", out_data, 4'hB);
    chk("rel_out_sel", out_sel, 2'd1);
    chk("rel_out_valid", out_valid, 1'b1);

    // drain with nothing valid: data and sel hold
    in_valid = 4'b0000;
    #1;
    chk("drain_in_ready", in_ready, 4'b0000);
    tick();
    chk("drain_out_valid", out_valid, 1'b0);
    chk("drain_out_data", out_data, 4'hB);
    chk("drain_out_sel", out_sel, 2'd1);

    // selected channel not valid
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    chk("inv_in_ready", in_ready, 4'b0000);
    tick();
    chk("inv_out_valid", out_valid, 1'b0);

`ifdef MUX_RR_EN
    // round-robin fairness over all four channels
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #0;
      chk("rr_in_ready", in_ready, 4'(1 << (i % 4)));
      tick();
      chk("rr_out_sel", out_sel, 2'(i % 4));
      chk("rr_out_data", out_data, ch[i % 4]);
    end

    // move ptr to 3, then sparse wrap 0 -> 1, leaving ptr at 2
    in_valid = 4'b0100;
    tick();
    chk("rr_p3_out_sel", out_sel, 2'd2);
    in_valid = 4'b0011;
    #1;
    chk("wrap_in_ready0", in_ready, 4'b0001);
    tick();
    chk("wrap_out_sel0", out_sel, 2'd0);
    chk("wrap_out_data0", out_data, 4'hA);
    #1;
    chk("wrap_in_ready1", in_ready, 4'b0010);
    tick();
    chk("wrap_out_sel1", out_sel, 2'd1);
    in_valid = 4'hF;
    #1;
    chk("wrap_ptr2", in_ready, 4'b0100);
    tick();

    // ptr (now 3) survives a manual-mode transfer
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    #1;
    chk("mc_man_in_ready", in_ready, 4'b0001);
    tick();
    mode = 1'b1; in_valid = 4'hF;
    #1;
    chk("mc_rr_in_ready", in_ready, 4'b1000);
    tick();
    chk("mc_rr_out_sel", out_sel, 2'd3);
    in_valid = 4'b0001;
    tick();
`else
    // mode is ignored without round-robin support
    mode = 1'b1; sel = 2'd3; in_valid = 4'b1001;
    #1;
    chk("noRR_in_ready", in_ready, 4'b1000);
    tick();
    chk("noRR_out_sel", out_sel, 2'd3);
    chk("noRR_out_data", out_data, 4'hD);
`endif

    // reset while a word is held under backpressure
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'hF;
    tick();
    chk("rl_hold_valid", out_valid, 1'b1);
    chk("rl_hold_data", out_data, 4'hB);
    rst = 1'b1;
    #1;
    chk("rl_in_ready", in_ready, 4'b0000);
    tick();
    chk("rl_out_valid", out_valid, 1'b0);
    chk("rl_out_data", out_data, 4'h0);
    chk("rl_out_sel", out_sel, 2'd0);
    rst = 1'b0;
`ifdef MUX_RR_EN
    mode = 1'b1; out_ready = 1'b1;
    #1;
    chk("rl_ptr0", in_ready, 4'b0001);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
